// File: rtl/ms_unity_arb.sv
// Round-robin arbiter for the shared unity resource used by the multi-step command decoders.
// Grants one core at a time, drains its memory access before handing over, and can revoke a stuck grant.
module ms_unity_arb #(
  parameter int unsigned CCoreCnt = 4,
  parameter int unsigned CIdxW    = 2,
  parameter int unsigned CHoldMax = 1024
) (
  input  logic                AClkH,
  input  logic                AResetHN,
  input  logic [CCoreCnt-1:0] AUnityReq,
  input  logic [CCoreCnt-1:0] AMemPend,
  output logic [CCoreCnt-1:0] AUnityAck,
  output logic [CIdxW-1:0]    AOwnerIdx,
  output logic                AOwnerVld,
  output logic                ATimeout
);

  localparam int unsigned       CHoldW    = 16;
  localparam int unsigned       CSumW     = CIdxW + 1;
  localparam bit                CHoldEn   = (CHoldMax != 0);
  localparam logic [CHoldW-1:0] CHoldLast = CHoldEn ? CHoldW'(CHoldMax - 1) : '0;
  localparam logic [CHoldW-1:0] CHoldSat  = '1;
  localparam logic [CSumW-1:0]  CCoreSum  = CSumW'(CCoreCnt);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StDrain = 2'd2
  } stateT;

  stateT               state, stateNxt;
  logic [CIdxW-1:0]    rrPtr, rrPtrNxt;
  logic [CHoldW-1:0]   holdCnt, holdCntNxt;
  logic [CCoreCnt-1:0] banned, bannedNxt;
  logic [CCoreCnt-1:0] ackNxt;
  logic [CIdxW-1:0]    ownerIdxNxt;
  logic                timeoutNxt;

  logic [CCoreCnt-1:0]   elig;
  logic [CCoreCnt-1:0]   ownerOh;
  logic                  ownerReq;
  logic                  ownerPend;
  logic [CIdxW-1:0]      ptrAfterOwner;
  logic [CIdxW-1:0]      arbPtr;
  logic [2*CCoreCnt-1:0] eligDbl;
  logic [CCoreCnt-1:0]   eligRot;
  logic                  pickVld;
  logic [CIdxW-1:0]      pickOfs;
  logic [CSumW-1:0]      pickSum;
  logic [CIdxW-1:0]      pickIdx;
  logic [CCoreCnt-1:0]   pickOh;

  assign elig = AUnityReq & ~banned;

  // Owner decode and the pointer position just past the owner
  always_comb begin
    ownerOh = '0;
    for (int unsigned k = 0; k < CCoreCnt; k++) begin
      ownerOh[k] = (AOwnerIdx == CIdxW'(k));
    end
    ownerReq      = |(AUnityReq & ownerOh);
    ownerPend     = |(AMemPend & ownerOh);
    ptrAfterOwner = (AOwnerIdx == CIdxW'(CCoreCnt - 1)) ? '0 : AOwnerIdx + CIdxW'(1);
  end

  // In DRAIN the pointer moves past the owner and is used in the same cycle
  assign arbPtr = (state == StDrain) ? ptrAfterOwner : rrPtr;

  // Rotate so arbPtr sits at bit 0, take the lowest set bit, rotate back
  always_comb begin
    eligDbl = {elig, elig} >> arbPtr;
    eligRot = eligDbl[CCoreCnt-1:0];
    pickVld = 1'b0;
    pickOfs = '0;
    for (int unsigned j = 0; j < CCoreCnt; j++) begin
      if (!pickVld && eligRot[j]) begin
        pickVld = 1'b1;
        pickOfs = CIdxW'(j);
      end
    end
    pickSum = {1'b0, arbPtr} + {1'b0, pickOfs};
    if (pickSum >= CCoreSum) begin
      pickSum = pickSum - CCoreSum;
    end
    pickIdx = pickSum[CIdxW-1:0];
    pickOh  = '0;
    for (int unsigned k = 0; k < CCoreCnt; k++) begin
      pickOh[k] = pickVld && (pickIdx == CIdxW'(k));
    end
  end

  // Next-state and next-output logic
  always_comb begin
    stateNxt    = state;
    rrPtrNxt    = rrPtr;
    holdCntNxt  = holdCnt;
    bannedNxt   = banned & AUnityReq;
    ackNxt      = AUnityAck;
    ownerIdxNxt = AOwnerIdx;
    timeoutNxt  = 1'b0;

    unique case (state)
      StIdle: begin
        ackNxt = '0;
        if (pickVld) begin
          ackNxt      = pickOh;
          ownerIdxNxt = pickIdx;
          holdCntNxt  = '0;
          stateNxt    = StGrant;
        end
      end
      StGrant: begin
        if (!ownerReq) begin
          ackNxt   = '0;
          stateNxt = StDrain;
        end else if (CHoldEn && (holdCnt == CHoldLast)) begin
          ackNxt     = '0;
          timeoutNxt = 1'b1;
          bannedNxt  = bannedNxt | ownerOh;
          stateNxt   = StDrain;
        end else if (holdCnt != CHoldSat) begin
          holdCntNxt = holdCnt + CHoldW'(1);
        end
      end
      StDrain: begin
        ackNxt = '0;
        if (!ownerPend) begin
          rrPtrNxt = ptrAfterOwner;
          if (pickVld) begin
            ackNxt      = pickOh;
            ownerIdxNxt = pickIdx;
            holdCntNxt  = '0;
            stateNxt    = StGrant;
          end else begin
            stateNxt = StIdle;
          end
        end
      end
      default: begin
        ackNxt   = '0;
        stateNxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      state     <= StIdle;
      rrPtr     <= '0;
      holdCnt   <= '0;
      banned    <= '0;
      AUnityAck <= '0;
      AOwnerIdx <= '0;
      AOwnerVld <= 1'b0;
      ATimeout  <= 1'b0;
    end else begin
      state     <= stateNxt;
      rrPtr     <= rrPtrNxt;
      holdCnt   <= holdCntNxt;
      banned    <= bannedNxt;
      AUnityAck <= ackNxt;
      AOwnerIdx <= ownerIdxNxt;
      AOwnerVld <= |ackNxt;
      ATimeout  <= timeoutNxt;
    end
  end

endmodule

// File: tb/tb_ms_unity_arb.sv
// Directed bench for ms_unity_arb (4 cores, hold limit 8): per-cycle vector table
// followed by a hand-written asynchronous reset sequence.
module tb_ms_unity_arb;

  logic       clk = 1'b0;
  logic       rstN;
  logic [3:0] req;
  logic [3:0] pend;
  logic [3:0] ack;
  logic [1:0] idx;
  logic       vld;
  logic       tmo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ms_unity_arb #(
    .CCoreCnt(4),
    .CIdxW   (2),
    .CHoldMax(8)
  ) dut (
    .AClkH    (clk),
    .AResetHN (rstN),
    .AUnityReq(req),
    .AMemPend (pend),
    .AUnityAck(ack),
    .AOwnerIdx(idx),
    .AOwnerVld(vld),
    .ATimeout (tmo)
  );

  typedef struct {
    string      name;
    int         rep;
    logic [3:0] req;
    logic [3:0] pend;
    logic [3:0] ack;
    logic [1:0] idx;
    logic       tmo;
  } vecT;

  vecT vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void addV(input string n, input int rep, input logic [3:0] rq,
                               input logic [3:0] pd, input logic [3:0] ak,
                               input logic [1:0] ix, input logic t);
    vecT v;
    v.name = n; v.rep = rep; v.req = rq; v.pend = pd; v.ack = ak; v.idx = ix; v.tmo = t;
    vecs.push_back(v);
  endfunction

  initial begin
    // name, cycles, req, pend, expected ack, idx, timeout (outputs after the edge)
    addV("single_grant",   5, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
    addV("single_release", 1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    addV("single_idle",    1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    addV("rr_core1",       3, 4'b0111, 4'b0000, 4'b0010, 2'd1, 1'b0);
    addV("rr_rel1",        1, 4'b0101, 4'b0000, 4'b0000, 2'd1, 1'b0);
    addV("rr_core2",       3, 4'b0111, 4'b0000, 4'b0100, 2'd2, 1'b0);
    addV("rr_rel2",        1, 4'b0011, 4'b0000, 4'b0000, 2'd2, 1'b0);
    addV("rr_core0",       3, 4'b0111, 4'b0000, 4'b0001, 2'd0, 1'b0);
    addV("rr_rel0",        1, 4'b0110, 4'b0000, 4'b0000, 2'd0, 1'b0);
    addV("rr_core1b",      2, 4'b0111, 4'b0000, 4'b0010, 2'd1, 1'b0);
    addV("rr_rel_all",     2, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);
    addV("drain_grant2",   1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    addV("drain_ignore3",  1, 4'b1100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    addV("drain_wait",     4, 4'b1000, 4'b0100, 4'b0000, 2'd2, 1'b0);
    addV("drain_grant3",   2, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b0);
    addV("drain_rel3",     1, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0);
    addV("drain_idle",     1, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0);
    addV("to_grant1",      1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
    addV("to_hold1",       7, 4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0);
    addV("to_revoke",      1, 4'b0011, 4'b0000, 4'b0000, 2'd1, 1'b1);
    addV("to_grant0",      2, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0);
    addV("to_rel0",        1, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0);
    addV("to_banned1",     2, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0);
    addV("to_drop1",       1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    addV("to_regrant1",    1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
    addV("edge_hold1",     7, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
    addV("edge_release",   1, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);
    addV("edge_notban",    1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
    addV("edge_rel",       2, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);

    rstN = 1'b0;
    req  = '0;
    pend = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack", 32'(ack), 32'(4'b0000));
    chk("reset_idx", 32'(idx), 32'(2'd0));
    chk("reset_vld", 32'(vld), 32'(1'b0));
    chk("reset_tmo", 32'(tmo), 32'(1'b0));
    @(negedge clk);
    rstN = 1'b1;

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        req  = vecs[i].req;
        pend = vecs[i].pend;
        @(posedge clk);
        #1;
        chk($sformatf("%s[%0d] ack", vecs[i].name, r), 32'(ack), 32'(vecs[i].ack));
        chk($sformatf("%s[%0d] idx", vecs[i].name, r), 32'(idx), 32'(vecs[i].idx));
        chk($sformatf("%s[%0d] vld", vecs[i].name, r), 32'(vld), 32'(|vecs[i].ack));
        chk($sformatf("%s[%0d] tmo", vecs[i].name, r), 32'(tmo), 32'(vecs[i].tmo));
        chk($sformatf("%s[%0d] onehot", vecs[i].name, r), 32'($onehot0(ack)), 32'(1));
        @(negedge clk);
      end
    end

    // Reset between edges while core 2 holds the grant (pointer was 2 beforehand)
    req  = 4'b0100;
    pend = 4'b0000;
    @(posedge clk);
    #1;
    chk("rst_pre_ack", 32'(ack), 32'(4'b0100));
    chk("rst_pre_idx", 32'(idx), 32'(2'd2));
    @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    chk("rst_async_ack", 32'(ack), 32'(4'b0000));
    chk("rst_async_vld", 32'(vld), 32'(1'b0));
    chk("rst_async_idx", 32'(idx), 32'(2'd0));
    chk("rst_async_tmo", 32'(tmo), 32'(1'b0));
    @(negedge clk);
    rstN = 1'b1;
    req  = 4'b1010;
    @(posedge clk);
    #1;
    chk("rst_ptr0_ack", 32'(ack), 32'(4'b0010));
    chk("rst_ptr0_idx", 32'(idx), 32'(2'd1));
    chk("rst_ptr0_vld", 32'(vld), 32'(1'b1));
    @(negedge clk);
    req = 4'b0000;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ms_unity_arb.md
Name: ms_unity_arb

Overview:
- Round-robin arbiter for the shared "unity" resource requested by the multi-step command decoders of several CPU cores.
- Each core's decoder raises its unity request during a multi-step command and waits for the acknowledge before continuing.
- The block grants one owner at a time and drains the owner's pending memory access before handing over.
- An optional hold timeout stops a stuck core from starving the others.

Parameters:
- CCoreCnt, 4, number of requesting cores (2..8).
- CIdxW, 2, width of owner index; must satisfy 2**CIdxW >= CCoreCnt.
- CHoldMax, 1024, maximum grant length in cycles (1..65535); 0 disables the timeout.

Ports:
- AClkH  in  1  system clock, rising edge.
- AResetHN  in  1  asynchronous active-low reset.
- AUnityReq  in  CCoreCnt  per-core request, level, held until acknowledged and done.
- AMemPend  in  CCoreCnt  per-core "memory transaction outstanding".
- AUnityAck  out  CCoreCnt  per-core grant, registered, one-hot or zero.
- AOwnerIdx  out  CIdxW  index of the current or last owner.
- AOwnerVld  out  1  a grant is active (equals OR of AUnityAck).
- ATimeout  out  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Clocking and reset: one clock, AClkH. Reset is asynchronous, active-low on AResetHN.
- Reset values:
  - AUnityAck=0, AOwnerVld=0, AOwnerIdx=0, ATimeout=0.
  - State=IDLE, RrPtr=0, HoldCnt=0, Banned mask=0.
- Eligibility: Elig = AUnityReq & ~Banned.
- Banned bit k clears on any cycle where AUnityReq[k]=0.
- Arbitration (combinational pick): the first eligible index scanning RrPtr, RrPtr+1, … with wrap modulo CCoreCnt.
- State IDLE:
  - If Elig!=0: latch winner into AOwnerIdx, set AUnityAck[winner]=1 on the next edge, HoldCnt=0, go GRANT.
  - Grant latency from request is 1 cycle.
- State GRANT:
  - AUnityAck stays asserted while AUnityReq[owner]=1. HoldCnt increments every cycle and saturates at 65535.
  - If AUnityReq[owner]=0: clear ack on the next edge, go DRAIN.
  - Else if CHoldMax!=0 and HoldCnt==CHoldMax-1: clear ack, pulse ATimeout for 1 cycle, set Banned[owner]=1, go DRAIN.
  - Requests from other cores are ignored while in GRANT.
- State DRAIN (at least 1 cycle, ack low):
  - Wait while AMemPend[owner]=1.
  - When AMemPend[owner]=0: RrPtr=(owner+1) mod CCoreCnt, then arbitrate in the same cycle using the new pointer.
  - If Elig!=0: go GRANT with the new winner (ack on the next edge). Else go IDLE.
  - Minimum gap between two grants: 1 cycle with all acks low.
- Single core in a loop: the same core may be re-granted if it is the only eligible requester. A timed-out core is not re-granted until it drops its request for at least 1 cycle.
- Simultaneous events:
  - Owner request drop on the timeout cycle: treated as a normal release; no ATimeout, no ban.
  - Request arriving on the same cycle another is released: evaluated in DRAIN as above.
- AMemPend of non-owners is ignored.
- Reset asserted mid-grant: all outputs go to reset values immediately (asynchronously); ban mask and pointer are cleared.
- Invariants:
  - AUnityAck is never multi-hot.
  - Ack is never asserted to a core whose request was low in the arbitration cycle.

Test Plan:
1. Single request: Req=0001 at cycle 0 → Ack=0001 at cycle 1, OwnerIdx=0. Req drops at cycle 5 → Ack=0 at cycle 6, IDLE by cycle 7 with AMemPend=0.
2. Round robin: Req=0111 held, each core holds 3 cycles after ack → grant order 0,1,2,0. There is 1 idle-ack cycle between grants.
3. Memory drain: owner 2 releases while AMemPend[2]=1 for 4 cycles; core 3 is requesting → Ack[3] asserts exactly 1 cycle after AMemPend[2] falls.
4. Timeout: CHoldMax=8, core 1 holds its request indefinitely; core 0 is requesting → ATimeout pulse 8 cycles after Ack[1] rose, then Ack[0]. Core 1 is not re-granted until its request toggles low.
5. Release on the timeout cycle: the owner drops Req on the HoldCnt==CHoldMax-1 cycle → no ATimeout and no ban; the next grant proceeds normally.
6. Reset mid-grant: assert AResetHN=0 during GRANT between clock edges → AUnityAck=0 immediately. After release, Req=1000 → Ack=1000 one cycle later (RrPtr restarted at 0).
